// File: rtl/nor_pkg.sv
// Shared types and constants for the NOR parallel-port bus controller.
package nor_pkg;

    localparam int NOR_DQ_W   = 16;
    localparam int NOR_ADDR_W = 26;
    localparam int T_BUSY_MAX = 1 << 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RD_PULSE,
        ST_WR_PULSE,
        ST_HOLD,
        ST_BUSY_DLY,
        ST_BUSY_WAIT,
        ST_DONE
    } nor_state_t;

    // Phase counter reload: a phase of t cycles counts t-1 down to 0.
    function automatic logic [7:0] cnt_load(input int t);
        return 8'(t - 1);
    endfunction

endpackage

// File: rtl/nor_sync2.sv
// Two-flop synchronizer for the asynchronous RY/BY# pin; resets to "ready" (1).
module nor_sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nor_bus_ctrl.sv
// Asynchronous NOR read / single-word write sequencer with programmable phase timing.
// Optional RY/BY# wait timeout enabled by defining NOR_BUSY_TIMEOUT_EN.
module nor_bus_ctrl
    import nor_pkg::*;
#(
    parameter int ADDR_W     = NOR_ADDR_W,
    parameter int T_SETUP    = 1,
    parameter int T_RD       = 8,
    parameter int T_WE       = 4,
    parameter int T_HOLD     = 2,
    parameter int T_BUSY_DLY = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_wait_busy,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [NOR_DQ_W-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [NOR_DQ_W-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic                nor_ce_n,
    output logic                nor_oe_n,
    output logic                nor_we_n,
    output logic [ADDR_W-1:0]   nor_addr,
    output logic [NOR_DQ_W-1:0] nor_dq_o,
    output logic                nor_dq_oe,
    input  logic [NOR_DQ_W-1:0] nor_dq_i,
    input  logic                nor_ry_by,
    output nor_state_t          dbg_state
);

    // Handshake: a request transfers on a rising CLK edge where req_valid && req_ready;
    // rsp_valid is a single-cycle pulse with no back-pressure.

    nor_state_t state;
    logic [7:0] cnt;
    logic       lat_wr;
    logic       lat_wait;
    logic       ry_sync;

`ifdef NOR_BUSY_TIMEOUT_EN
    logic [19:0] busy_cnt;
    logic        err_pend;
`endif

    assign dbg_state = state;

    nor_sync2 u_ry_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (nor_ry_by),
        .q   (ry_sync)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            lat_wr    <= 1'b0;
            lat_wait  <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            nor_ce_n  <= 1'b1;
            nor_oe_n  <= 1'b1;
            nor_we_n  <= 1'b1;
            nor_addr  <= '0;
            nor_dq_o  <= '0;
            nor_dq_oe <= 1'b0;
`ifdef NOR_BUSY_TIMEOUT_EN
            busy_cnt  <= 20'd0;
            err_pend  <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        lat_wr    <= req_write;
                        lat_wait  <= req_write && req_wait_busy;
                        nor_ce_n  <= 1'b0;
                        nor_addr  <= req_addr;
                        if (req_write) begin
                            nor_dq_o  <= req_wdata;
                            nor_dq_oe <= 1'b1;
                        end
                        cnt   <= cnt_load(T_SETUP);
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == 8'd0) begin
                        if (lat_wr) begin
                            nor_we_n <= 1'b0;
                            cnt      <= cnt_load(T_WE);
                            state    <= ST_WR_PULSE;
                        end else begin
                            nor_oe_n <= 1'b0;
                            cnt      <= cnt_load(T_RD);
                            state    <= ST_RD_PULSE;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_RD_PULSE: begin
                    if (cnt == 8'd0) begin
                        rsp_rdata <= nor_dq_i;
                        nor_oe_n  <= 1'b1;
                        cnt       <= cnt_load(T_HOLD);
                        state     <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_WR_PULSE: begin
                    if (cnt == 8'd0) begin
                        nor_we_n <= 1'b1;
                        cnt      <= cnt_load(T_HOLD);
                        state    <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == 8'd0) begin
                        nor_ce_n  <= 1'b1;
                        nor_dq_oe <= 1'b0;
                        if (lat_wait) begin
                            cnt   <= cnt_load(T_BUSY_DLY);
                            state <= ST_BUSY_DLY;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_BUSY_DLY: begin
                    // Gives the device time to pull RY/BY# low before we start looking at it.
                    if (cnt == 8'd0) begin
                        state <= ST_BUSY_WAIT;
`ifdef NOR_BUSY_TIMEOUT_EN
                        busy_cnt <= 20'd0;
                        err_pend <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_BUSY_WAIT: begin
                    if (ry_sync) begin
                        state <= ST_DONE;
`ifdef NOR_BUSY_TIMEOUT_EN
                    end else if (busy_cnt == 20'(T_BUSY_MAX - 1)) begin
                        err_pend <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        busy_cnt <= busy_cnt + 20'd1;
`endif
                    end
                end
                ST_DONE: begin
                    rsp_valid <= 1'b1;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
`ifdef NOR_BUSY_TIMEOUT_EN
                    rsp_err   <= err_pend;
                    err_pend  <= 1'b0;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nor_bus_ctrl.sv
// Directed bench for nor_bus_ctrl: a cycle-offset reference model checks every output
// on every cycle, plus hand-computed latency/pulse-width/data pins.
module tb_nor_bus_ctrl;
    import nor_pkg::*;

    localparam int TS = 1;
    localparam int TR = 8;
    localparam int TW = 4;
    localparam int TH = 2;
    localparam int TB = 2;

    // ---------------- clock / reset / DUT ----------------
    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid, req_ready, req_write, req_wait_busy;
    logic [25:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic        nor_ce_n, nor_oe_n, nor_we_n, nor_dq_oe, nor_ry_by;
    logic [25:0] nor_addr;
    logic [15:0] nor_dq_o, nor_dq_i;
    nor_state_t  dbg_state;

    always #5 CLK = ~CLK;

    nor_bus_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_wait_busy (req_wait_busy),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .nor_ce_n      (nor_ce_n),
        .nor_oe_n      (nor_oe_n),
        .nor_we_n      (nor_we_n),
        .nor_addr      (nor_addr),
        .nor_dq_o      (nor_dq_o),
        .nor_dq_oe     (nor_dq_oe),
        .nor_dq_i      (nor_dq_i),
        .nor_ry_by     (nor_ry_by),
        .dbg_state     (dbg_state)
    );

    // Flash device stand-in: drives an address-dependent word while OE# is low.
    function automatic logic [15:0] dev_word(input logic [25:0] a);
        return a[15:0] ^ 16'hE0A4;
    endfunction

    assign nor_dq_i = nor_oe_n ? 16'h0000 : dev_word(nor_addr);

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_k = 0;
    bit          e_rst = 1'b0;
    bit          e_ready = 1'b0;
    bit          e_rsp = 1'b0;
    bit          m_have = 1'b0;
    bit          m_active = 1'b0;
    int          m_a = 0;
    int          m_rsp_edge = -1;
    bit          m_wr = 1'b0;
    bit          m_wait = 1'b0;
    logic [25:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    int          acc_cnt = 0;
    bit          ry_hist[$];
    int          oe_low_cnt = 0;
    int          we_low_cnt = 0;
    int          dq_oe_cnt = 0;

    function automatic int pulse_len(input bit wr);
        return wr ? TW : TR;
    endfunction

    function automatic int lat_of(input bit wr);
        return 1 + TS + pulse_len(wr) + TH;
    endfunction

    // Advance the model to the next rising edge, using the inputs that edge will sample.
    task automatic advance();
        bit old_ready;
        old_ready = e_ready;
        m_k++;
        ry_hist.push_back(RST ? 1'b1 : nor_ry_by);
        e_rsp = 1'b0;
        if (RST) begin
            e_rst    = 1'b1;
            e_ready  = 1'b0;
            m_have   = 1'b0;
            m_active = 1'b0;
        end else begin
            e_rst = 1'b0;
            if (m_active) begin
                // Busy wait ends once RY/BY# seen high at the pin two edges earlier.
                if (m_wait && m_rsp_edge < 0 && m_k >= m_a + lat_of(m_wr) + TB && ry_hist[m_k-2])
                    m_rsp_edge = m_k + 1;
                if (m_k == m_rsp_edge) begin
                    e_rsp    = 1'b1;
                    e_ready  = 1'b1;
                    m_active = 1'b0;
                end else begin
                    e_ready = 1'b0;
                end
            end else if (old_ready && req_valid) begin
                m_have     = 1'b1;
                m_active   = 1'b1;
                m_a        = m_k;
                m_wr       = req_write;
                m_wait     = req_write && req_wait_busy;
                m_addr     = req_addr;
                m_wdata    = req_wdata;
                m_rsp_edge = m_wait ? -1 : m_k + lat_of(req_write);
                e_ready    = 1'b0;
                acc_cnt++;
            end else begin
                e_ready = 1'b1;
            end
        end
    endtask

    task automatic compare();
        int n;
        bit ce_low, oe_low, we_low;
        ce_low = 1'b0;
        oe_low = 1'b0;
        we_low = 1'b0;
        if (m_have && !e_rst) begin
            n      = m_k - m_a;
            ce_low = (n <= TS + pulse_len(m_wr) + TH - 1);
            oe_low = !m_wr && n >= TS && n <= TS + TR - 1;
            we_low = m_wr && n >= TS && n <= TS + TW - 1;
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        chk("rsp_err", 32'(rsp_err), 32'(0));
        chk("nor_ce_n", 32'(nor_ce_n), 32'(!ce_low));
        chk("nor_oe_n", 32'(nor_oe_n), 32'(!oe_low));
        chk("nor_we_n", 32'(nor_we_n), 32'(!we_low));
        chk("nor_dq_oe", 32'(nor_dq_oe), 32'(m_wr && ce_low));
        chk("oe_we_overlap", 32'(!nor_oe_n && !nor_we_n), 32'(0));
        chk("dq_oe_while_oe", 32'(nor_dq_oe && !nor_oe_n), 32'(0));
        if (ce_low)
            chk("nor_addr", 32'(nor_addr), 32'(m_addr));
        if (m_wr && ce_low)
            chk("nor_dq_o", 32'(nor_dq_o), 32'(m_wdata));
        if (e_rsp && !m_wr)
            chk("rsp_rdata", 32'(rsp_rdata), 32'(dev_word(m_addr)));
        if (e_rst) begin
            chk("rst_addr", 32'(nor_addr), 32'(0));
            chk("rst_dq_o", 32'(nor_dq_o), 32'(0));
            chk("rst_rdata", 32'(rsp_rdata), 32'(0));
        end
        if (!nor_oe_n) oe_low_cnt++;
        if (!nor_we_n) we_low_cnt++;
        if (nor_dq_oe) dq_oe_cnt++;
    endtask

    initial begin
        ry_hist.push_back(1'b1);
        #2 advance();
        forever begin
            @(negedge CLK);
            compare();
            advance();
        end
    end

    // ---------------- driver tasks ----------------
    // Returns the number of rising edges until the model registers an accept (0 = timeout).
    task automatic wait_acc(input int c0, output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge CLK);
            if (acc_cnt != c0) begin
                n = i;
                break;
            end
        end
        #1;
    endtask

    task automatic set_req(input bit wr, input bit wt, input logic [25:0] a, input logic [15:0] wd);
        req_write     = wr;
        req_wait_busy = wt;
        req_addr      = a;
        req_wdata     = wd;
    endtask

    task automatic issue(input bit wr, input bit wt, input logic [25:0] a, input logic [15:0] wd);
        int n;
        set_req(wr, wt, a, wd);
        req_valid = 1'b1;
        wait_acc(acc_cnt, n);
        chk("accept_in_time", 32'(n != 0), 32'(1));
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge CLK);
            #1;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge CLK);
            #1;
            if (!m_active) begin
                ok = 1;
                break;
            end
        end
        chk("idle_in_time", 32'(ok), 32'(1));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int lat, lat2, n, oe0, we0, dq0, rsp_seen;
        RST       = 1'b1;
        req_valid = 1'b0;
        nor_ry_by = 1'b1;
        set_req(1'b0, 1'b0, 26'h0, 16'h0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;

        // Read with default timing.
        oe0 = oe_low_cnt;
        issue(1'b0, 1'b0, 26'h1234567, 16'h0000);
        wait_rsp(lat);
        chk("rd_latency", 32'(lat), 32'(12));
        chk("rd_data_lit", 32'(rsp_rdata), 32'(16'hA5C3));
        chk("oe_low_cycles", 32'(oe_low_cnt - oe0), 32'(8));

        // Write without busy wait.
        we0 = we_low_cnt;
        dq0 = dq_oe_cnt;
        issue(1'b1, 1'b0, 26'h0000555, 16'h00AA);
        wait_rsp(lat);
        chk("wr_latency", 32'(lat), 32'(8));
        chk("we_low_cycles", 32'(we_low_cnt - we0), 32'(4));
        chk("dq_oe_cycles", 32'(dq_oe_cnt - dq0), 32'(7));

        // Write with busy wait; RY/BY# low for 50 edges starting after WE# rises.
        issue(1'b1, 1'b1, 26'h00002AA, 16'h0055);
        repeat (5) @(posedge CLK);
        #1 nor_ry_by = 1'b0;
        repeat (50) @(posedge CLK);
        #1 nor_ry_by = 1'b1;
        wait_rsp(lat2);
        chk("busy_latency", 32'(55 + lat2), 32'(59));

        // Three back-to-back reads with req_valid held high.
        set_req(1'b0, 1'b0, 26'h0000100, 16'h0);
        req_valid = 1'b1;
        wait_acc(acc_cnt, n);
        chk("b2b_first", 32'(n), 32'(1));
        set_req(1'b0, 1'b0, 26'h3FFFFFF, 16'h0);
        wait_acc(acc_cnt, n);
        chk("b2b_spacing1", 32'(n), 32'(13));
        set_req(1'b0, 1'b1, 26'h0ABCDEF, 16'h0);
        wait_acc(acc_cnt, n);
        chk("b2b_spacing2", 32'(n), 32'(13));
        req_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a read pulse.
        issue(1'b0, 1'b0, 26'h0001000, 16'h0);
        repeat (4) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_ce_n", 32'(nor_ce_n), 32'(1));
        chk("rst_oe_n", 32'(nor_oe_n), 32'(1));
        chk("rst_dq_oe", 32'(nor_dq_oe), 32'(0));
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'(1));
        rsp_seen = 0;
        repeat (20) begin
            @(posedge CLK);
            #1;
            if (rsp_valid) rsp_seen++;
        end
        chk("rst_no_rsp", 32'(rsp_seen), 32'(0));

        // Recovery: write to the lowest address with all-ones data.
        issue(1'b1, 1'b0, 26'h0000000, 16'hFFFF);
        wait_rsp(lat);
        chk("wr2_latency", 32'(lat), 32'(8));
        repeat (3) @(posedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nor_bus_ctrl.md
Name: nor_bus_ctrl

Overview:
- Sequences asynchronous read and single-word write (command/program) cycles on the 16-bit parallel NOR port of the NR1B-SQT56 bridge.
- Drives CE#/OE#/WE#, the address bus and the DQ bus using programmable cycle counts.
- Upstream logic (QSPI command decoder) issues one request at a time over a valid/ready handshake and gets a response pulse back.
- Instantiated in the top level. Its outputs replace the tie-offs on NOR_CE, NOR_OE, NOR_WE, NOR_A*, and on the NOR_DQ* pins through the top-level tristate.

Parameters:
- ADDR_W, 26: NOR word address width (A0..A25).
- T_SETUP, 1: CLK cycles from CE# low and address valid to OE#/WE# low. Range 1..15.
- T_RD, 8: CLK cycles OE# is held low before DQ is sampled. Range 1..255.
- T_WE, 4: CLK cycles WE# is held low. Range 1..255.
- T_HOLD, 2: CLK cycles CE# stays low after OE#/WE# rise. Range 1..15.
- T_BUSY_DLY, 2: CLK cycles after WE# rises before RY/BY# is sampled. Range 1..15.

Ports:
- CLK, in, 1: system clock.
- RST, in, 1: synchronous reset, active-high.
- req_valid, in, 1: request present.
- req_ready, out, 1: controller idle, so a request can be accepted.
- req_write, in, 1: 1 = write cycle, 0 = read cycle.
- req_wait_busy, in, 1: write only; wait for RY/BY# release before responding.
- req_addr, in, ADDR_W: word address.
- req_wdata, in, 16: write data.
- rsp_valid, out, 1: one-cycle completion pulse.
- rsp_rdata, out, 16: read data, valid while rsp_valid is high.
- rsp_err, out, 1: busy timeout (see Optional Feature). Always 0 if the feature is absent.
- nor_ce_n, out, 1: NOR chip enable, active low.
- nor_oe_n, out, 1: NOR output enable, active low.
- nor_we_n, out, 1: NOR write enable, active low.
- nor_addr, out, ADDR_W: NOR address bus.
- nor_dq_o, out, 16: DQ drive value.
- nor_dq_oe, out, 1: DQ output enable (top-level tristate).
- nor_dq_i, in, 16: DQ input.
- nor_ry_by, in, 1: RY/BY# pin, asynchronous.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0 for the reset cycle, then 1; rsp_valid=0; rsp_rdata=0; rsp_err=0; nor_ce_n=1; nor_oe_n=1; nor_we_n=1; nor_addr=0; nor_dq_o=0; nor_dq_oe=0.
- A reset asserted mid-operation aborts the cycle immediately. All outputs return to their reset values on the next edge and no rsp_valid is emitted.
- nor_ry_by passes through a 2-FF synchronizer (reset to 1) before use.
- A request is accepted when req_valid && req_ready. Address, write data and flags are latched at acceptance. req_ready drops on the following edge and stays 0 until the state returns to IDLE.
- One down-counter, 8 bits wide, is reloaded on each state entry with (parameter − 1). The state advances when the counter reaches 0.
- States and transitions:
  - IDLE: on accept go to SETUP. nor_ce_n=0, nor_addr=latched address. For a write, nor_dq_o=wdata and nor_dq_oe=1.
  - SETUP (T_SETUP cycles): go to RD_PULSE (nor_oe_n=0) or WR_PULSE (nor_we_n=0).
  - RD_PULSE (T_RD cycles): on the last cycle sample nor_dq_i into rsp_rdata, nor_oe_n=1, go to HOLD.
  - WR_PULSE (T_WE cycles): then nor_we_n=1, go to HOLD. Data and address stay stable.
  - HOLD (T_HOLD cycles): then nor_ce_n=1 and nor_dq_oe=0. Go to BUSY_DLY if the request was a write with req_wait_busy set, otherwise to DONE.
  - BUSY_DLY (T_BUSY_DLY cycles): go to BUSY_WAIT.
  - BUSY_WAIT: stay until synchronized RY/BY# = 1, then go to DONE.
  - DONE: rsp_valid=1 for exactly one cycle, return to IDLE, req_ready=1.
- Latency from accept to rsp_valid = 1 + T_SETUP + T_RD (or T_WE) + T_HOLD cycles. With BUSY_WAIT, add T_BUSY_DLY plus the time RY/BY# stays low.
- Defaults give a read latency of 12 cycles and a no-wait write latency of 8 cycles.
- OE# and WE# are never low simultaneously. nor_dq_oe is never 1 while nor_oe_n=0.
- A request arriving while busy is held off by req_ready=0. The counter reload is exact, so there is no wrap-around.
- req_wait_busy is ignored on reads.

Optional Feature:
- Macro: NOR_BUSY_TIMEOUT_EN.
- When defined: localparam T_BUSY_MAX = 2^20 cycles. A 20-bit counter runs in BUSY_WAIT. If it expires before RY/BY# rises, the controller goes to DONE with rsp_err=1 for that response.
- When undefined: BUSY_WAIT waits indefinitely and rsp_err is tied to 0.

Decomposition:
- Package nor_pkg holds:
  - the state enumeration;
  - NOR_DQ_W=16 and NOR_ADDR_W=26;
  - the T_BUSY_MAX constant.
- One sub-module, nor_sync2: the 2-FF synchronizer for nor_ry_by, with reset value 1.

Test Plan:
- Read, defaults, addr=0x1234567, DQ model returns 0xA5C3 after OE# low → rsp_valid 12 cycles after accept, rsp_rdata=0xA5C3, OE# low for exactly 8 cycles.
- Write without wait, addr=0x555, wdata=0x00AA → WE# low 4 cycles, DQ=0x00AA with nor_dq_oe=1 for the whole CE# window, rsp_valid 8 cycles after accept.
- Write with req_wait_busy=1, RY/BY# held low 50 cycles after WE# rises → rsp_valid only after RY/BY# returns high plus 2 synchronizer cycles, rsp_err=0.
- Back-to-back: req_valid held high with 3 queued reads → each accepted only when req_ready=1, CE# high for at least 1 cycle between cycles, no overlap of OE#/WE#.
- RST asserted during RD_PULSE → next edge: CE#/OE#/WE#=1, nor_dq_oe=0, no rsp_valid, req_ready=1 one cycle after reset release.
- With NOR_BUSY_TIMEOUT_EN defined and RY/BY# stuck low → rsp_valid with rsp_err=1 after 2^20 cycles in BUSY_WAIT.
